// File: rtl/macro_readout_sched_pkg.sv
// Shared constants for the hash-macro readback scheduler: defaults, FSM state codes, helpers.
package macro_readout_sched_pkg;

    localparam int unsigned NUM_MACROS_DEF  = 4;
    localparam int unsigned NONCE_BYTES_DEF = 4;
    localparam logic [5:0]  NONCE_BASE_DEF  = 6'h00;
    localparam logic [5:0]  CLR_ADDR_DEF    = 6'h3F;
    localparam int unsigned RD_LAT_DEF      = 2;
    localparam int unsigned CLR_WAIT_DEF    = 4;
    localparam int unsigned FIFO_DEPTH_DEF  = 4;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ARB   = 3'd1;
    localparam logic [2:0] ST_READ  = 3'd2;
    localparam logic [2:0] ST_CLEAR = 3'd3;
    localparam logic [2:0] ST_COOL  = 3'd4;

    // Index width with a floor of one bit so single-entry sets still get a field.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/macro_readout_sched_if.sv
// Macro-side and result-side signals of the readback scheduler.
interface macro_readout_sched_if
    import macro_readout_sched_pkg::*;
#(
    parameter int unsigned NUM_MACROS  = NUM_MACROS_DEF,
    parameter int unsigned NONCE_BYTES = NONCE_BYTES_DEF,
    parameter int unsigned FIFO_DEPTH  = FIFO_DEPTH_DEF
) ();
    localparam int unsigned MW = idx_width(NUM_MACROS);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic                     ENABLE;
    logic [NUM_MACROS-1:0]    DATA_AVAILABLE;
    logic [7:0]               DATA_FROM_HASH;
    logic [NUM_MACROS-1:0]    MACRO_RD_SELECT;
    logic [NUM_MACROS-1:0]    MACRO_WR_SELECT;
    logic [5:0]               HASH_ADDR;
    logic [7:0]               DATA_TO_HASH;
    logic                     res_valid;
    logic                     res_ready;
    logic [MW-1:0]            res_macro;
    logic [8*NONCE_BYTES-1:0] res_nonce;
    logic [CW-1:0]            res_count;
    logic                     busy;

    modport master (
        input  ENABLE, DATA_AVAILABLE, DATA_FROM_HASH, res_ready,
        output MACRO_RD_SELECT, MACRO_WR_SELECT, HASH_ADDR, DATA_TO_HASH,
        output res_valid, res_macro, res_nonce, res_count, busy
    );

    modport slave (
        output ENABLE, DATA_AVAILABLE, DATA_FROM_HASH, res_ready,
        input  MACRO_RD_SELECT, MACRO_WR_SELECT, HASH_ADDR, DATA_TO_HASH,
        input  res_valid, res_macro, res_nonce, res_count, busy
    );

endinterface

// File: rtl/macro_readout_sched_result_fifo.sv
// Synchronous FIFO holding {macro, nonce} records; head reads zero while empty.
module macro_readout_sched_result_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign count    = count_q;
    assign pop_data = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping; simultaneous push/pop leaves count unchanged.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage array; contents need no reset since empty masks the head.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/macro_readout_sched.sv
// Round-robin readback of hash-macro nonces: read bytes, clear the flag, queue the record.
module macro_readout_sched
    import macro_readout_sched_pkg::*;
#(
    parameter int unsigned NUM_MACROS  = NUM_MACROS_DEF,
    parameter int unsigned NONCE_BYTES = NONCE_BYTES_DEF,
    parameter logic [5:0]  NONCE_BASE  = NONCE_BASE_DEF,
    parameter logic [5:0]  CLR_ADDR    = CLR_ADDR_DEF,
    parameter int unsigned RD_LAT      = RD_LAT_DEF,
    parameter int unsigned CLR_WAIT    = CLR_WAIT_DEF,
    parameter int unsigned FIFO_DEPTH  = FIFO_DEPTH_DEF
) (
    input  logic                    M1_CLK,
    input  logic                    RST_M1_N,
    macro_readout_sched_if.master   bus
);
    localparam int unsigned MW = idx_width(NUM_MACROS);
    localparam int unsigned KW = idx_width(NONCE_BYTES);
    localparam int unsigned RW = MW + 8 * NONCE_BYTES;

    logic [2:0]               state_q, state_d;
    logic [MW-1:0]            rr_ptr_q, rr_ptr_d, grant_q, grant_d, grant_c;
    logic                     grant_ok;
    logic [KW-1:0]            byte_q, byte_d;
    logic [7:0]               cnt_q, cnt_d;
    logic [8*NONCE_BYTES-1:0] nonce_q;
    logic [NUM_MACROS-1:0]    rd_sel_q, rd_sel_d, wr_sel_q, wr_sel_d;
    logic [5:0]               addr_q, addr_d;
    logic [7:0]               dto_q, dto_d;
    logic                     capture, push, fifo_full, fifo_empty;
    logic [RW-1:0]            head;

    // First requester at or after ptr, searching circularly; MSB flags a hit.
    function automatic logic [MW:0] rr_pick(input logic [NUM_MACROS-1:0] req,
                                            input logic [MW-1:0] ptr);
        logic [MW:0] res;
        int unsigned idx;
        res = '0;
        for (int unsigned i = 0; i < NUM_MACROS; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= NUM_MACROS) idx = idx - NUM_MACROS;
            if (!res[MW] && req[MW'(idx)]) res = {1'b1, MW'(idx)};
        end
        return res;
    endfunction

    // Next-state and next-output decode; outputs are computed one cycle ahead and registered.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        byte_d   = byte_q;
        cnt_d    = cnt_q;
        rd_sel_d = rd_sel_q;
        wr_sel_d = wr_sel_q;
        addr_d   = addr_q;
        dto_d    = dto_q;
        capture  = 1'b0;
        push     = 1'b0;
        {grant_ok, grant_c} = rr_pick(bus.DATA_AVAILABLE, rr_ptr_q);
        case (state_q)
            ST_IDLE: begin
                if (bus.ENABLE && (|bus.DATA_AVAILABLE) && !fifo_full) state_d = ST_ARB;
            end
            ST_ARB: begin
                if (grant_ok) begin
                    state_d  = ST_READ;
                    grant_d  = grant_c;
                    byte_d   = '0;
                    cnt_d    = '0;
                    rr_ptr_d = (grant_c == MW'(NUM_MACROS - 1)) ? '0 : grant_c + 1'b1;
                    rd_sel_d = '0;
                    rd_sel_d[grant_c] = 1'b1;
                    addr_d   = NONCE_BASE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                if (cnt_q == 8'(RD_LAT - 1)) begin
                    capture = 1'b1;
                    cnt_d   = '0;
                    if (byte_q == KW'(NONCE_BYTES - 1)) begin
                        state_d  = ST_CLEAR;
                        rd_sel_d = '0;
                        wr_sel_d = '0;
                        wr_sel_d[grant_q] = 1'b1;
                        addr_d   = CLR_ADDR;
                        dto_d    = 8'h01;
                    end else begin
                        byte_d = byte_q + 1'b1;
                        addr_d = NONCE_BASE + 6'(byte_q) + 6'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_CLEAR: begin
                // FIFO space was checked before ARB and can only have grown since.
                push     = 1'b1;
                wr_sel_d = '0;
                cnt_d    = '0;
                state_d  = ST_COOL;
            end
            ST_COOL: begin
                // Hold off re-arbitration while the macro's flag drops.
                if (cnt_q >= 8'(CLR_WAIT - 1)) state_d = ST_IDLE;
                else                           cnt_d   = cnt_q + 8'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, pointer and registered macro-interface outputs.
    always_ff @(posedge M1_CLK) begin
        if (!RST_M1_N) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            byte_q   <= '0;
            cnt_q    <= '0;
            nonce_q  <= '0;
            rd_sel_q <= '0;
            wr_sel_q <= '0;
            addr_q   <= '0;
            dto_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            byte_q   <= byte_d;
            cnt_q    <= cnt_d;
            rd_sel_q <= rd_sel_d;
            wr_sel_q <= wr_sel_d;
            addr_q   <= addr_d;
            dto_q    <= dto_d;
            for (int unsigned k = 0; k < NONCE_BYTES; k++) begin
                if (capture && byte_q == KW'(k)) nonce_q[8*k +: 8] <= bus.DATA_FROM_HASH;
            end
        end
    end

    macro_readout_sched_result_fifo #(
        .WIDTH (RW),
        .DEPTH (FIFO_DEPTH)
    ) u_result_fifo (
        .clk       (M1_CLK),
        .rst_n     (RST_M1_N),
        .push      (push),
        .push_data ({grant_q, nonce_q}),
        .pop       (bus.res_ready),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (bus.res_count)
    );

    assign bus.MACRO_RD_SELECT         = rd_sel_q;
    assign bus.MACRO_WR_SELECT         = wr_sel_q;
    assign bus.HASH_ADDR               = addr_q;
    assign bus.DATA_TO_HASH            = dto_q;
    assign bus.busy                    = (state_q != ST_IDLE);
    assign bus.res_valid               = !fifo_empty;
    assign {bus.res_macro, bus.res_nonce} = head;

endmodule

// File: tb/tb_macro_readout_sched.sv
// Directed bench for macro_readout_sched with a behavioural macro model and record scoreboard.
module tb_macro_readout_sched;
    import macro_readout_sched_pkg::*;

    localparam int unsigned NM    = 4;
    localparam int unsigned NB    = 4;
    localparam int unsigned RL    = 2;
    localparam int unsigned CWAIT = 4;
    localparam int unsigned FD    = 4;
    localparam int unsigned MW    = idx_width(NM);
    localparam int unsigned RECW  = MW + 8 * NB;
    localparam int unsigned LAT   = 1 + NB * RL + 1;

    logic          M1_CLK   = 1'b0;
    logic          RST_M1_N = 1'b0;
    int            checks   = 0;
    int            errors   = 0;
    logic [7:0]    mbytes [NM][NB];
    logic [NM-1:0] da       = '0;
    logic [NM-1:0] set_req  = '0;
    logic [NM-1:0] clr_mask;
    logic          da_flush = 1'b1;
    logic [7:0]    hash_q   = 8'h00;
    logic [RECW-1:0] exp_q [$];

    always #5 M1_CLK = ~M1_CLK;

    macro_readout_sched_if #(.NUM_MACROS(NM), .NONCE_BYTES(NB), .FIFO_DEPTH(FD)) bus ();

    assign bus.DATA_AVAILABLE = da;
    assign bus.DATA_FROM_HASH = hash_q;

    macro_readout_sched #(
        .NUM_MACROS  (NM),
        .NONCE_BYTES (NB),
        .NONCE_BASE  (NONCE_BASE_DEF),
        .CLR_ADDR    (CLR_ADDR_DEF),
        .RD_LAT      (RL),
        .CLR_WAIT    (CWAIT),
        .FIFO_DEPTH  (FD)
    ) dut (
        .M1_CLK   (M1_CLK),
        .RST_M1_N (RST_M1_N),
        .bus      (bus)
    );

    // Macro clear decode: write of 01 to the clear address drops that macro's flag.
    always_comb begin
        clr_mask = '0;
        for (int m = 0; m < NM; m++) begin
            clr_mask[m] = (bus.MACRO_WR_SELECT == NM'(1 << m)) &&
                          (bus.HASH_ADDR == CLR_ADDR_DEF) && (bus.DATA_TO_HASH == 8'h01);
        end
    end

    // Macro model: flags set by stimulus, read data appears one cycle after address.
    always @(posedge M1_CLK) begin
        int a;
        if (da_flush) da <= '0;
        else          da <= (da | set_req) & ~clr_mask;
        a = int'(bus.HASH_ADDR) - int'(NONCE_BASE_DEF);
        hash_q <= 8'h00;
        for (int m = 0; m < NM; m++) begin
            if (bus.MACRO_RD_SELECT == NM'(1 << m) && a >= 0 && a < int'(NB))
                hash_q <= mbytes[m][a];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, expv);
        end
    endtask

    // Consumer side: every popped record must match the scoreboard head.
    always @(negedge M1_CLK) begin
        if (RST_M1_N && bus.res_valid && bus.res_ready) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_record: observed macro %0d nonce %0h, required none",
                       bus.res_macro, bus.res_nonce);
            end
            if (exp_q.size() != 0) chk("record", 64'({bus.res_macro, bus.res_nonce}),
                                       64'(exp_q.pop_front()));
        end
    end

    function automatic logic [RECW-1:0] rec(input int m);
        logic [8*NB-1:0] n;
        for (int k = 0; k < NB; k++) n[8*k +: 8] = mbytes[m][k];
        return {MW'(m), n};
    endfunction

    task automatic step();
        @(posedge M1_CLK);
        #1;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic raise(input logic [NM-1:0] mask);
        set_req = mask;
        step();
        set_req = '0;
    endtask

    task automatic drain(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0 && !bus.busy) break;
            step();
        end
        chk({tag, "_left"}, 64'(exp_q.size()), 64'd0);
        chk({tag, "_idle"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int busy_at, valid_at, rd_n, rd_bad, wr_n, wr_bad, other;
        bit found;
        logic [5:0] addrs [$];

        bus.ENABLE    = 1'b1;
        bus.res_ready = 1'b1;
        for (int m = 0; m < NM; m++)
            for (int k = 0; k < NB; k++) mbytes[m][k] = 8'((m << 4) | (k + 5));
        mbytes[2][0] = 8'h11; mbytes[2][1] = 8'h22; mbytes[2][2] = 8'h33; mbytes[2][3] = 8'h44;

        // Reset held with every flag high
        steps(2);
        da_flush = 1'b0;
        set_req  = '1;
        steps(4);
        chk("rst_rd_sel", 64'(bus.MACRO_RD_SELECT), 64'd0);
        chk("rst_wr_sel", 64'(bus.MACRO_WR_SELECT), 64'd0);
        chk("rst_addr",   64'(bus.HASH_ADDR),       64'd0);
        chk("rst_dto",    64'(bus.DATA_TO_HASH),    64'd0);
        chk("rst_valid",  64'(bus.res_valid),       64'd0);
        chk("rst_count",  64'(bus.res_count),       64'd0);
        chk("rst_busy",   64'(bus.busy),            64'd0);
        chk("rst_macro",  64'(bus.res_macro),       64'd0);
        chk("rst_nonce",  64'(bus.res_nonce),       64'd0);
        set_req  = '0;
        da_flush = 1'b1;
        step();
        da_flush = 1'b0;
        RST_M1_N = 1'b1;

        // Fairness from rr_ptr=0, then wrap check: 0 before 3 only if pointer returned to 0
        for (int m = 0; m < NM; m++) exp_q.push_back(rec(m));
        raise(4'b1111);
        drain("fair", 400);
        exp_q.push_back(rec(0));
        exp_q.push_back(rec(3));
        raise(4'b1001);
        drain("wrap", 200);

        // Single read of macro 2 with cycle trace
        exp_q.push_back(rec(2));
        chk("single_exp", 64'(rec(2)), {30'd0, 2'd2, 32'h44332211});
        raise(4'b0100);
        busy_at = -1; valid_at = -1; rd_n = 0; rd_bad = 0; wr_n = 0; wr_bad = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.busy && busy_at < 0) busy_at = c;
            if (bus.res_valid && valid_at < 0) valid_at = c;
            if (bus.MACRO_RD_SELECT != '0) begin
                rd_n++;
                addrs.push_back(bus.HASH_ADDR);
                if (bus.MACRO_RD_SELECT != 4'b0100) rd_bad++;
            end
            if (bus.MACRO_WR_SELECT != '0) begin
                wr_n++;
                if (bus.MACRO_WR_SELECT != 4'b0100 || bus.HASH_ADDR != 6'h3F ||
                    bus.DATA_TO_HASH != 8'h01) wr_bad++;
            end
            step();
        end
        chk("single_rd_cycles", 64'(rd_n), 64'(NB * RL));
        chk("single_rd_bad",    64'(rd_bad), 64'd0);
        chk("single_wr_pulses", 64'(wr_n), 64'd1);
        chk("single_wr_bad",    64'(wr_bad), 64'd0);
        chk("single_latency",   64'(valid_at - busy_at), 64'(LAT));
        for (int i = 0; i < addrs.size(); i++)
            chk($sformatf("single_addr%0d", i), 64'(addrs[i]), 64'(i / RL));
        chk("single_left", 64'(exp_q.size()), 64'd0);

        // Backpressure: pointer now 3, so order 3,0,1,2; fifth request stalls until a pop
        bus.res_ready = 1'b0;
        exp_q.push_back(rec(3));
        exp_q.push_back(rec(0));
        exp_q.push_back(rec(1));
        exp_q.push_back(rec(2));
        raise(4'b1111);
        for (int i = 0; i < 300; i++) begin
            if (bus.res_count == 3'd4 && !bus.busy) break;
            step();
        end
        steps(5);
        chk("bp_count_full", 64'(bus.res_count), 64'd4);
        chk("bp_busy",       64'(bus.busy), 64'd0);
        chk("bp_head_macro", 64'(bus.res_macro), 64'd3);
        for (int k = 0; k < NB; k++) mbytes[1][k] = 8'(8'hA0 + k);
        exp_q.push_back(rec(1));
        raise(4'b0010);
        steps(20);
        chk("bp_stall_busy",  64'(bus.busy), 64'd0);
        chk("bp_stall_count", 64'(bus.res_count), 64'd4);
        chk("bp_flag_held",   64'(da), 64'b0010);
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (da == '0 && !bus.busy) break;
            step();
        end
        chk("bp_fifth_cleared", 64'(da), 64'd0);
        chk("bp_count_again",   64'(bus.res_count), 64'd4);
        bus.res_ready = 1'b1;
        drain("bp", 100);
        chk("bp_count_empty", 64'(bus.res_count), 64'd0);

        // ENABLE dropped during byte 1: pointer 2, so macro 0 goes first and macro 1 must wait
        exp_q.push_back(rec(0));
        raise(4'b0011);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.MACRO_RD_SELECT != '0 && bus.HASH_ADDR == 6'd1) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk("en_reached_byte1", 64'(found), 64'd1);
        bus.ENABLE = 1'b0;
        other = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.MACRO_RD_SELECT == 4'b0010) other++;
            step();
        end
        chk("en_no_new_arb", 64'(other), 64'd0);
        chk("en_record_done", 64'(exp_q.size()), 64'd0);
        chk("en_idle", 64'(bus.busy), 64'd0);
        chk("en_flag_left", 64'(da), 64'b0010);
        bus.ENABLE = 1'b1;
        exp_q.push_back(rec(1));
        drain("en_resume", 100);

        // Reset mid-READ with one record already buffered: both vanish
        bus.res_ready = 1'b0;
        raise(4'b0101);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.res_count == 3'd1 && bus.MACRO_RD_SELECT != '0) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk("mid_reached_read", 64'(found), 64'd1);
        steps(3);
        RST_M1_N = 1'b0;
        da_flush = 1'b1;
        step();
        chk("mid_rd_sel", 64'(bus.MACRO_RD_SELECT), 64'd0);
        chk("mid_wr_sel", 64'(bus.MACRO_WR_SELECT), 64'd0);
        chk("mid_count",  64'(bus.res_count), 64'd0);
        chk("mid_busy",   64'(bus.busy), 64'd0);
        RST_M1_N = 1'b1;
        da_flush = 1'b0;
        bus.res_ready = 1'b1;
        steps(30);
        chk("mid_post_count", 64'(bus.res_count), 64'd0);
        chk("mid_post_valid", 64'(bus.res_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
